// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants and instruction-port types.
package cpu_pkg;

  // Canonical no-op (addi x0, x0, 0) in the low word of a 64-bit fetch beat.
  localparam logic [63:0] INSTR_NOP = 64'h0000_0000_0000_0013;

  typedef enum logic {
    IMEM_IDLE = 1'b0,
    IMEM_BUS  = 1'b1
  } imem_state_t;

  // One-entry instruction holding register.
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [63:0] data;
    logic        fault;
  } imem_hold_t;

endpackage

// File: rtl/imem_port_if.sv
// Wishbone-style instruction read bus between imem_port and the memory slave.
interface imem_port_if #(
  parameter int unsigned BUS_ADDR_W = 32
);
  logic                  bus_cyc_out;
  logic                  bus_stb_out;
  logic [BUS_ADDR_W-1:0] bus_adr_out;
  logic [63:0]           bus_dat_in;
  logic                  bus_ack_in;
  logic                  bus_err_in;

  modport master (
    output bus_cyc_out, bus_stb_out, bus_adr_out,
    input  bus_dat_in, bus_ack_in, bus_err_in
  );

  modport slave (
    input  bus_cyc_out, bus_stb_out, bus_adr_out,
    output bus_dat_in, bus_ack_in, bus_err_in
  );
endinterface

// File: rtl/imem_port.sv
// Fetch-to-bus instruction port with a one-entry holding register and fault tagging.
module imem_port
  import cpu_pkg::*;
#(
  parameter int unsigned BUS_ADDR_W = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         instr_read_in,
  input  logic [63:0]  instr_address_in,
  input  logic         fence_i_in,
  output logic [63:0]  instr_read_value_out,
  output logic         instr_fault_out,
  output logic         stall_out,
  imem_port_if.master  bus
);

  localparam int unsigned          CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]     CNT_SAT  = CNT_W'(TIMEOUT);
  localparam imem_hold_t           HOLD_RST = '{valid: 1'b0, addr: 64'd0,
                                                data: INSTR_NOP, fault: 1'b0};

  imem_state_t           state_q, state_d;
  imem_hold_t            hold_q, hold_d;
  logic [BUS_ADDR_W-1:0] req_q, req_d;
  logic                  cyc_q, cyc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic hit;
  logic miss;
  logic illegal;
  logic done;

  assign hit     = hold_q.valid && (hold_q.addr == instr_address_in);
  assign miss    = instr_read_in && !hit;
  assign illegal = (instr_address_in[2:0] != 3'd0) ||
                   ((instr_address_in >> BUS_ADDR_W) != 64'd0);
  assign done    = bus.bus_ack_in || bus.bus_err_in || (cnt_q == CNT_LAST);

  assign stall_out            = miss;
  assign instr_read_value_out = hold_q.data;
  assign instr_fault_out      = hold_q.fault;
  assign bus.bus_cyc_out      = cyc_q;
  assign bus.bus_stb_out      = cyc_q;
  assign bus.bus_adr_out      = req_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IMEM_IDLE;
      hold_q  <= HOLD_RST;
      req_q   <= '0;
      cyc_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      req_q   <= req_d;
      cyc_q   <= cyc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: leave IDLE only for a legal miss, leave BUS on any completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IMEM_IDLE: if (miss && !illegal) state_d = IMEM_BUS;
      IMEM_BUS:  if (done)             state_d = IMEM_IDLE;
      default:   state_d = IMEM_IDLE;
    endcase
  end

  // Datapath: bus request launch, completion capture, fault substitution, fence.
  always_comb begin
    hold_d = hold_q;
    req_d  = req_q;
    cyc_d  = cyc_q;
    cnt_d  = cnt_q;
    case (state_q)
      IMEM_IDLE: begin
        if (miss) begin
          if (illegal) begin
            hold_d = '{valid: 1'b1, addr: instr_address_in,
                       data: INSTR_NOP, fault: 1'b1};
          end else begin
            req_d = instr_address_in[BUS_ADDR_W-1:0];
            cyc_d = 1'b1;
            cnt_d = '0;
          end
        end
      end
      IMEM_BUS: begin
        if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
        if (done) begin
          // Error outranks ack; timeout is the case with neither.
          hold_d.valid = 1'b1;
          hold_d.addr  = 64'(req_q);
          hold_d.fault = bus.bus_err_in || !bus.bus_ack_in;
          hold_d.data  = (bus.bus_ack_in && !bus.bus_err_in) ? bus.bus_dat_in : INSTR_NOP;
          cyc_d        = 1'b0;
        end
      end
      default: cyc_d = 1'b0;
    endcase
    // Fence still lets a concurrent completion write data, but leaves it invalid.
    if (fence_i_in) hold_d.valid = 1'b0;
  end

endmodule
